// File: rtl/multicycle_ctrl.sv
// Main control FSM of the 16-bit multicycle RISC-V core: sequences fetch/decode/
// execute/memory/writeback, drives ALU op and operand selects, stalls on mem_ready.
module multicycle_ctrl #(
  parameter int unsigned IMM_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  input  logic       zero,
  input  logic       less_greater,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_JAL     = 4'd10,
    S_ILLEGAL = 4'd11
  } state_e;

  typedef enum logic [3:0] {
    OP_R    = 4'b0000,
    OP_ADDI = 4'b0001,
    OP_LW   = 4'b0010,
    OP_SW   = 4'b0011,
    OP_BEQ  = 4'b0100,
    OP_BNE  = 4'b0101,
    OP_JAL  = 4'b0110
  } opcode_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // IMM_W only documents the instruction format; extension happens in the datapath.
  if (IMM_W == 0) begin : g_no_imm
  end

  state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    iord        = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    pc_src      = 2'b00;
    illegal     = 1'b0;
    state       = state_q;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        case (opcode)
          OP_R:          state_d = S_EXEC_R;
          OP_ADDI:       state_d = S_EXEC_I;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_JAL:        state_d = S_JAL;
          default:       state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a   = 2'b10;
        alu_control = funct;
        state_d     = (funct[2:1] == 2'b11) ? S_ILLEGAL : S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 2'b10;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_write    = (opcode == OP_BNE) ? less_greater : zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_src     = 2'b01;
        pc_write   = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset masks every request and select in the same cycle it is high.
    if (rst) begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      iord        = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      mem_to_reg  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      alu_control = ALU_ADD;
      pc_src      = 2'b00;
      illegal     = 1'b0;
      state       = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: instructions are expanded into an
// expected per-cycle trace, then replayed and compared on every falling edge.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pcw, irw, iord, mrd, mwr, rw;
    logic [1:0] mtr, sa, sb;
    logic [2:0] alu;
    logic [1:0] pcs;
    logic       ill;
    logic [3:0] st;
  } obs_t;

  typedef struct {
    logic        rst, mr, z, lg;
    logic [3:0]  op;
    logic [2:0]  fn;
    obs_t        exp;
    int unsigned ins;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = '0;
  logic [2:0] funct = '0;
  logic       zero = 1'b0, less_greater = 1'b0, mem_ready = 1'b0;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, illegal;
  logic [1:0] mem_to_reg, alu_src_a, alu_src_b, pc_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  vec_t        q[$];
  vec_t        cur;
  logic        vld = 1'b0;
  int unsigned nvec = 0, nmis = 0, ins_id = 0, vidx = 0;

  multicycle_ctrl #(.IMM_W(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .less_greater(less_greater), .mem_ready(mem_ready), .pc_write(pc_write),
    .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .pc_src(pc_src),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic push(input obs_t e, input logic r, input logic mr, input logic z,
                      input logic lg, input logic [3:0] op, input logic [2:0] fn);
    vec_t v;
    v.rst = r; v.mr = mr; v.z = z; v.lg = lg; v.op = op; v.fn = fn;
    v.exp = e; v.ins = ins_id;
    q.push_back(v);
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Expected trace of one instruction; fst/mst = wait cycles in fetch / memory.
  task automatic instr(input logic [3:0] op, input logic [2:0] fn, input int unsigned fst,
                       input int unsigned mst, input logic z, input logic lg,
                       output int unsigned n);
    obs_t e;
    int unsigned start;
    start = q.size();
    ins_id++;
    for (int unsigned i = 0; i <= fst; i++) begin
      e = '0; e.mrd = 1'b1; e.sb = 2'b01; e.pcw = (i == fst); e.irw = (i == fst);
      push(e, 1'b0, i == fst, rb(), rb(), 4'($urandom), 3'($urandom));
    end
    e = '0; e.st = 4'd1; e.sa = 2'b01; e.sb = 2'b10;
    push(e, 1'b0, rb(), rb(), rb(), op, fn);
    case (op)
      4'd0: begin
        e = '0; e.st = 4'd6; e.sa = 2'b10; e.alu = fn;
        push(e, 1'b0, rb(), rb(), rb(), op, fn);
        e = '0;
        if (fn >= 3'd6) begin e.st = 4'd11; e.ill = 1'b1; end
        else begin e.st = 4'd8; e.rw = 1'b1; end
        push(e, 1'b0, rb(), rb(), rb(), op, fn);
      end
      4'd1: begin
        e = '0; e.st = 4'd7; e.sa = 2'b10; e.sb = 2'b10;
        push(e, 1'b0, rb(), rb(), rb(), op, fn);
        e = '0; e.st = 4'd8; e.rw = 1'b1;
        push(e, 1'b0, rb(), rb(), rb(), op, fn);
      end
      4'd2, 4'd3: begin
        e = '0; e.st = 4'd2; e.sa = 2'b10; e.sb = 2'b10;
        push(e, 1'b0, rb(), rb(), rb(), op, fn);
        for (int unsigned i = 0; i <= mst; i++) begin
          e = '0; e.iord = 1'b1;
          if (op == 4'd2) begin e.st = 4'd3; e.mrd = 1'b1; end
          else begin e.st = 4'd5; e.mwr = 1'b1; end
          push(e, 1'b0, i == mst, rb(), rb(), op, fn);
        end
        if (op == 4'd2) begin
          e = '0; e.st = 4'd4; e.rw = 1'b1; e.mtr = 2'b01;
          push(e, 1'b0, rb(), rb(), rb(), op, fn);
        end
      end
      4'd4, 4'd5: begin
        e = '0; e.st = 4'd9; e.sa = 2'b10; e.alu = 3'b001; e.pcs = 2'b01;
        e.pcw = (op == 4'd4) ? z : lg;
        push(e, 1'b0, rb(), z, lg, op, fn);
      end
      4'd6: begin
        e = '0; e.st = 4'd10; e.rw = 1'b1; e.mtr = 2'b10; e.pcs = 2'b01; e.pcw = 1'b1;
        push(e, 1'b0, rb(), rb(), rb(), op, fn);
      end
      default: begin
        e = '0; e.st = 4'd11; e.ill = 1'b1;
        push(e, 1'b0, rb(), rb(), rb(), op, fn);
      end
    endcase
    n = q.size() - start;
  endtask

  task automatic pin(input int unsigned id, input int unsigned got, input int unsigned want);
    nvec++;
    if (got != want) begin
      nmis++;
      $display("FAIL pin%0d: model gives %0d, hand value %0d", id, got, want);
    end
  endtask

  task automatic rst_cycles(input int unsigned k);
    obs_t e;
    e = '0;
    for (int unsigned i = 0; i < k; i++)
      push(e, 1'b1, rb(), rb(), rb(), 4'($urandom), 3'($urandom));
  endtask

  always @(negedge clk) begin
    obs_t got;
    if (vld) begin
      got = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, mem_to_reg,
             alu_src_a, alu_src_b, alu_control, pc_src, illegal, state};
      nvec++;
      if (got !== cur.exp) begin
        nmis++;
        $display("FAIL vec%0d ins%0d: dut %h, expected %h", vidx, cur.ins, got, cur.exp);
      end
    end
  end

  initial begin
    int unsigned n, base;
    int unsigned lw_tr[7];
    obs_t e;
    lw_tr = '{0, 1, 2, 3, 3, 3, 4};

    rst_cycles(2);
    instr(4'd0, 3'd0, 0, 0, 1'b0, 1'b0, n); pin(1, n, 4);
    base = q.size();
    instr(4'd2, 3'd0, 0, 2, 1'b0, 1'b0, n); pin(2, n, 7);
    for (int unsigned i = 0; i < 7; i++) pin(10 + i, 32'(q[base + i].exp.st), lw_tr[i]);
    instr(4'd2, 3'd0, 1, 0, 1'b0, 1'b0, n); pin(3, n, 6);
    instr(4'd3, 3'd0, 0, 0, 1'b0, 1'b0, n); pin(4, n, 4);
    instr(4'd3, 3'd0, 2, 1, 1'b0, 1'b0, n);
    instr(4'd1, 3'd0, 0, 0, 1'b0, 1'b0, n); pin(5, n, 4);
    for (int unsigned f = 1; f < 6; f++) instr(4'd0, 3'(f), f % 2, 0, 1'b0, 1'b0, n);
    instr(4'd4, 3'd0, 0, 0, 1'b1, 1'b0, n); pin(6, n, 3);
    instr(4'd4, 3'd0, 0, 0, 1'b0, 1'b1, n);
    instr(4'd5, 3'd0, 0, 0, 1'b0, 1'b1, n);
    instr(4'd5, 3'd0, 0, 0, 1'b1, 1'b0, n);
    instr(4'd6, 3'd0, 0, 0, 1'b0, 1'b0, n); pin(7, n, 3);
    instr(4'd15, 3'd0, 0, 0, 1'b0, 1'b0, n); pin(8, n, 3);
    instr(4'd0, 3'd7, 0, 0, 1'b0, 1'b0, n); pin(9, n, 4);
    instr(4'd0, 3'd6, 0, 0, 1'b0, 1'b0, n);
    for (int unsigned o = 7; o < 15; o++) instr(4'(o), 3'd0, 0, 0, 1'b0, 1'b0, n);

    // SW abandoned by reset while stalled in the write state
    ins_id++;
    e = '0; e.mrd = 1'b1; e.sb = 2'b01; e.pcw = 1'b1; e.irw = 1'b1;
    push(e, 1'b0, 1'b1, rb(), rb(), 4'd9, 3'd0);
    e = '0; e.st = 4'd1; e.sa = 2'b01; e.sb = 2'b10;
    push(e, 1'b0, 1'b0, rb(), rb(), 4'd3, 3'd0);
    e = '0; e.st = 4'd2; e.sa = 2'b10; e.sb = 2'b10;
    push(e, 1'b0, 1'b0, rb(), rb(), 4'd3, 3'd0);
    e = '0; e.st = 4'd5; e.mwr = 1'b1; e.iord = 1'b1;
    push(e, 1'b0, 1'b0, rb(), rb(), 4'd3, 3'd0);
    push(e, 1'b0, 1'b0, rb(), rb(), 4'd3, 3'd0);
    e = '0;
    push(e, 1'b1, 1'b0, rb(), rb(), 4'd3, 3'd0);
    instr(4'd0, 3'd2, 0, 0, 1'b0, 1'b0, n);
    rst_cycles(2);
    instr(4'd2, 3'd0, 3, 0, 1'b0, 1'b0, n);

    @(posedge clk); #1;
    foreach (q[i]) begin
      cur = q[i]; vidx = i;
      rst = cur.rst; mem_ready = cur.mr; zero = cur.z; less_greater = cur.lg;
      opcode = cur.op; funct = cur.fn;
      vld = 1'b1;
      @(posedge clk); #1;
    end
    vld = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
